mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control sequencer that issues operations to the 32-bit ALU and drives the datapath muxes and strobes for one MIPS subset instruction at a time. It decodes opcode and funct into the 3-bit ALU operation code and consumes the ALU zero flag for branches. It also handshakes with instruction/data memory through a ready signal. It sits between the instruction register and the datapath, replacing the single-cycle combinational control path.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- opcode  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zf  in  1  ALU zero flag (1 = result==0)
- mem_ready  in  1  memory completes current read/write this cycle
- aluc  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- alusrca  out  1  0 = PC, 1 = reg A
- alusrcb  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write, ir_write, reg_write  out  1 each  strobes
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  PC load enable
- bad_op  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH: mem_read=1, iord=0, alusrca=0, alusrcb=01, aluc=010, pc_source=00; ir_write and pc_en asserted only when mem_ready=1, then -> DECODE; else stay.
- DECODE: alusrca=0, alusrcb=11, aluc=010 (branch target into ALUOut). Next: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXEC; beq (000100) -> BRANCH; j (000010) -> JUMP; addi (001000) -> ADDIEX when enabled; else bad_op=1 -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluc=010; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1; -> MEMWB on mem_ready. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_write=1, iord=1; -> FETCH on mem_ready; mem_write held until then.
- EXEC: alusrca=1, alusrcb=00; funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; -> RWB. Unknown funct: bad_op=1, aluc=010, -> FETCH, no writeback.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluc=110, pc_source=01, pc_en=zf -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- All outputs not listed for a state are 0; aluc defaults to 010.

## Timing
- State register updates on rising clk; all outputs are combinational from state (plus zf, mem_ready, funct where stated).
- rst=1 at a clock edge: state <= FETCH; while rst is high, all strobes (mem_read, mem_write, ir_write, reg_write, pc_en, bad_op) forced 0. rst mid-instruction abandons it with no further writes.
- Latency with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Each memory wait cycle adds exactly one cycle; strobes stay stable while waiting.
- bad_op pulses for exactly the DECODE or EXEC cycle.

## Configuration
- MC_CONTROL_ADDI_EN defined: opcode 001000 -> ADDIEX (alusrca=1, alusrcb=10, aluc=010) -> ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
- Undefined: states 10/11 unreachable, opcode 001000 is illegal (bad_op pulse in DECODE, -> FETCH).

## Test plan
- rst held 2 cycles, then R-type funct 100010, mem_ready=1 -> states 0,1,6,7,0; aluc=110 in EXEC; reg_write=1 with reg_dst=1 only in RWB.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1 and iord=1 throughout, reg_write=1 once in MEMWB; total 8 cycles.
- beq with zf=1 then zf=0 -> pc_en=1 with pc_source=01 in first, pc_en=0 in second; both return to FETCH after 3 cycles.
- Opcode 111111 -> bad_op=1 for one cycle in DECODE, no reg_write/mem_write, next state FETCH; R-type funct 000000 -> bad_op in EXEC.
- addi with and without MC_CONTROL_ADDI_EN -> 4-cycle writeback with reg_dst=0 vs bad_op pulse in DECODE.
- rst asserted during MEMWR with mem_ready=0 -> mem_write=0 in rst cycles, state=0 after the edge, no write completes.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-subset control sequencer (ALU op, datapath muxes, memory strobes).
// Define MC_CONTROL_ADDI_EN to add addi support (ADDIEX/ADDIWB); otherwise addi is illegal.
module mc_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zf,
   input  logic       mem_ready,
   output logic [2:0] aluc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] pc_source,
   output logic       pc_en,
   output logic       bad_op,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
   } state_t;
   state_t state_q, state_d;
   logic mr_r, mw_r, irw_r, rw_r, pe_r, bo_r;
   always_ff @(posedge clk)
      if (rst) state_q <= FETCH;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      aluc = 3'b010;
      alusrca = 1'b0;
      alusrcb = 2'b00;
      iord = 1'b0;
      reg_dst = 1'b0;
      mem_to_reg = 1'b0;
      pc_source = 2'b00;
      mr_r = 1'b0;
      mw_r = 1'b0;
      irw_r = 1'b0;
      rw_r = 1'b0;
      pe_r = 1'b0;
      bo_r = 1'b0;
      case (state_q)
         FETCH: begin
            mr_r = 1'b1;
            alusrcb = 2'b01;
            irw_r = mem_ready;
            pe_r = mem_ready;
            state_d = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (opcode)
               6'b100011, 6'b101011: state_d = MEMADR;
               6'b000000: state_d = EXEC;
               6'b000100: state_d = BRANCH;
               6'b000010: state_d = JUMP;
`ifdef MC_CONTROL_ADDI_EN
               6'b001000: state_d = ADDIEX;
`endif
               default: begin
                  bo_r = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (opcode == 6'b100011) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mr_r = 1'b1;
            iord = 1'b1;
            state_d = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            rw_r = 1'b1;
            mem_to_reg = 1'b1;
            state_d = FETCH;
         end
         MEMWR: begin
            mw_r = 1'b1;
            iord = 1'b1;
            state_d = mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            alusrca = 1'b1;
            state_d = RWB;
            case (funct)
               6'b100000: aluc = 3'b010;
               6'b100010: aluc = 3'b110;
               6'b100100: aluc = 3'b000;
               6'b100101: aluc = 3'b001;
               6'b101010: aluc = 3'b111;
               default: begin
                  bo_r = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         RWB: begin
            rw_r = 1'b1;
            reg_dst = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            alusrca = 1'b1;
            aluc = 3'b110;
            pc_source = 2'b01;
            pe_r = zf;
            state_d = FETCH;
         end
         JUMP: begin
            pc_source = 2'b10;
            pe_r = 1'b1;
            state_d = FETCH;
         end
`ifdef MC_CONTROL_ADDI_EN
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            rw_r = 1'b1;
            state_d = FETCH;
         end
`endif
         default: state_d = FETCH;
      endcase
   end
   // Reset suppresses every side effect so an abandoned instruction writes nothing.
   assign mem_read = mr_r & ~rst;
   assign mem_write = mw_r & ~rst;
   assign ir_write = irw_r & ~rst;
   assign reg_write = rw_r & ~rst;
   assign pc_en = pe_r & ~rst;
   assign bad_op = bo_r & ~rst;
   assign state = state_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-cycle vectors against hand-computed control words for mc_control.
module tb_mc_control;
   logic clk = 1'b0, rst = 1'b1, zf = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic [2:0] aluc;
   logic [1:0] alusrcb, pc_source;
   logic [3:0] state;
   logic alusrca, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, pc_en, bad_op;
   int checks = 0, errors = 0;

   mc_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zf(zf), .mem_ready(mem_ready),
      .aluc(aluc), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .pc_source(pc_source), .pc_en(pc_en), .bad_op(bad_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic r;
      logic [5:0] op;
      logic [5:0] fn;
      logic z;
      logic rdy;
      logic [20:0] e;
      logic [63:0] nm;
   } vec_t;
   vec_t tbl[$];

   // Control word: {state, aluc, alusrca, alusrcb, iord, mr, mw, irw, rw, rd, m2r, pc_source, pc_en, bad_op}
   function automatic logic [20:0] w(input logic [3:0] st, input logic [2:0] al, input logic a,
         input logic [1:0] b, input logic i, mr, mw, irw, rw, rd, m2r, input logic [1:0] ps,
         input logic pe, bo);
      return {st, al, a, b, i, mr, mw, irw, rw, rd, m2r, ps, pe, bo};
   endfunction

   task automatic cyc(input logic r, input logic [5:0] op, fn, input logic z, rdy,
         input logic [20:0] e, input logic [63:0] nm);
      logic [20:0] got;
      @(negedge clk);
      rst = r;
      opcode = op;
      funct = fn;
      zf = z;
      mem_ready = rdy;
      #1;
      got = {state, aluc, alusrca, alusrcb, iord, mem_read, mem_write, ir_write, reg_write,
             reg_dst, mem_to_reg, pc_source, pc_en, bad_op};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %0s state=%0d got=%h exp=%h", nm, state, got, e);
      end
   endtask

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

   initial begin
      logic [20:0] f_go, f_wait, dec;
      f_go   = w(4'd0, 3'b010, 0, 2'b01, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1, 0);
      f_wait = w(4'd0, 3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      dec    = w(4'd1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      tbl.push_back('{1, RT, 6'b100010, 0, 1, w(4'd0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "rst0"});
      tbl.push_back('{1, RT, 6'b100010, 0, 1, w(4'd0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "rst1"});
      tbl.push_back('{0, RT, 6'b100010, 0, 1, f_go, "sub_f"});
      tbl.push_back('{0, RT, 6'b100010, 0, 1, dec, "sub_d"});
      tbl.push_back('{0, RT, 6'b100010, 0, 1, w(4'd6, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "sub_ex"});
      tbl.push_back('{0, RT, 6'b100010, 0, 1, w(4'd7, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0), "sub_wb"});
      tbl.push_back('{0, BEQ, 6'd0, 1, 1, f_go, "beq1_f"});
      tbl.push_back('{0, BEQ, 6'd0, 1, 1, dec, "beq1_d"});
      tbl.push_back('{0, BEQ, 6'd0, 1, 1, w(4'd8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0), "beq1_br"});
      tbl.push_back('{0, BEQ, 6'd0, 0, 1, f_go, "beq0_f"});
      tbl.push_back('{0, BEQ, 6'd0, 0, 1, dec, "beq0_d"});
      tbl.push_back('{0, BEQ, 6'd0, 0, 1, w(4'd8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), "beq0_br"});
      tbl.push_back('{0, J, 6'd0, 0, 1, f_go, "j_f"});
      tbl.push_back('{0, J, 6'd0, 0, 1, dec, "j_d"});
      tbl.push_back('{0, J, 6'd0, 0, 1, w(4'd9, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0), "j_jmp"});
      tbl.push_back('{0, BAD, 6'd0, 0, 1, f_go, "bad_f"});
      tbl.push_back('{0, BAD, 6'd0, 0, 1, w(4'd1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "bad_d"});
      tbl.push_back('{0, RT, 6'b000000, 0, 1, f_go, "badfn_f"});
      tbl.push_back('{0, RT, 6'b000000, 0, 1, dec, "badfn_d"});
      tbl.push_back('{0, RT, 6'b000000, 0, 1, w(4'd6, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "badfn_ex"});
      tbl.push_back('{0, SW, 6'd0, 0, 0, f_wait, "sw_fw"});
      tbl.push_back('{0, SW, 6'd0, 0, 1, f_go, "sw_f"});
      tbl.push_back('{0, SW, 6'd0, 0, 1, dec, "sw_d"});
      tbl.push_back('{0, SW, 6'd0, 0, 1, w(4'd2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "sw_adr"});
      tbl.push_back('{0, SW, 6'd0, 0, 1, w(4'd5, 3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), "sw_wr"});
      foreach (tbl[k]) cyc(tbl[k].r, tbl[k].op, tbl[k].fn, tbl[k].z, tbl[k].rdy, tbl[k].e, tbl[k].nm);

      // Remaining R-type functs: only the EXEC aluc differs.
      begin
         logic [5:0] fns[4];
         logic [2:0] alus[4];
         fns = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
         alus = '{3'b010, 3'b000, 3'b001, 3'b111};
         for (int k = 0; k < 4; k++) begin
            cyc(0, RT, fns[k], 0, 1, f_go, "fn_f");
            cyc(0, RT, fns[k], 0, 1, dec, "fn_d");
            cyc(0, RT, fns[k], 0, 1, w(4'd6, alus[k], 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "fn_ex");
            cyc(0, RT, fns[k], 0, 1, w(4'd7, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0), "fn_wb");
         end
      end

      // lw with three memory wait cycles in MEMRD: 8 cycles total.
      cyc(0, LW, 6'd0, 0, 1, f_go, "lw_f");
      cyc(0, LW, 6'd0, 0, 1, dec, "lw_d");
      cyc(0, LW, 6'd0, 0, 0, w(4'd2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "lw_adr");
      for (int k = 0; k < 3; k++)
         cyc(0, LW, 6'd0, 0, 0, w(4'd3, 3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "lw_wait");
      cyc(0, LW, 6'd0, 0, 1, w(4'd3, 3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "lw_rd");
      cyc(0, LW, 6'd0, 0, 1, w(4'd4, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0), "lw_wb");

      // addi: writeback path when enabled, illegal opcode otherwise.
      cyc(0, ADDI, 6'd0, 0, 1, f_go, "addi_f");
`ifdef MC_CONTROL_ADDI_EN
      cyc(0, ADDI, 6'd0, 0, 1, dec, "addi_d");
      cyc(0, ADDI, 6'd0, 0, 1, w(4'd10, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "addi_ex");
      cyc(0, ADDI, 6'd0, 0, 1, w(4'd11, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0), "addi_wb");
`else
      cyc(0, ADDI, 6'd0, 0, 1, w(4'd1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1), "addi_bad");
`endif

      // Reset while a store waits on memory: the write is abandoned.
      cyc(0, SW, 6'd0, 0, 1, f_go, "rsw_f");
      cyc(0, SW, 6'd0, 0, 1, dec, "rsw_d");
      cyc(0, SW, 6'd0, 0, 0, w(4'd2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "rsw_adr");
      cyc(0, SW, 6'd0, 0, 0, w(4'd5, 3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0), "rsw_wr");
      cyc(1, SW, 6'd0, 0, 0, w(4'd5, 3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "rsw_rst");
      cyc(0, RT, 6'd0, 0, 0, f_wait, "rsw_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
